// File: rtl/jt10_adpcmx_seq.sv
`default_nettype none
// ============================================================================
// jt10_adpcmx_seq : per-channel ADPCM nibble sequencer with a ready/valid ROM
//                   byte port feeding a shared time-multiplexed decoder
// rev 1.0
// ============================================================================
module jt10_adpcmx_seq #(
  parameter  int CH  = 6,
  parameter  int SW  = 16,
  localparam int CHW = $clog2(CH),
  localparam int AW  = SW + 8
) (
  input  logic            rst_n,
  input  logic            clk,
  input  logic            cen,
  input  logic [CHW-1:0]  wr_ch,
  input  logic            wr_start,
  input  logic            wr_end,
  input  logic            wr_loop,
  input  logic [SW-1:0]   wr_data,
  input  logic            loop_in,
  input  logic [CH-1:0]   key_on,
  input  logic [CH-1:0]   key_off,
  output logic [AW-1:0]   rom_addr,
  output logic            rom_cs,
  input  logic [7:0]      rom_data,
  input  logic            rom_ok,
  output logic [3:0]      nib,
  output logic [CHW-1:0]  nib_ch,
  output logic            nib_valid,
  output logic            nib_clr,
  output logic [CH-1:0]   busy,
  output logic [CH-1:0]   flags,
  output logic [CH-1:0]   underrun,
  input  logic [CH-1:0]   clr_flags
);

  typedef enum logic [0:0] {F_IDLE = 1'b0, F_REQ = 1'b1} fstate_t;

  logic [SW-1:0]  start_r [CH];
  logic [SW-1:0]  end_r   [CH];
  logic [AW-1:0]  cur     [CH];
  logic [7:0]     bbyte   [CH];
  logic [CH-1:0]  loop_r;
  logic [CH-1:0]  hi;
  logic [CH-1:0]  bvld;
  logic [CH-1:0]  first_r;
  logic [CH-1:0]  play;
  logic [CHW-1:0] sl;
  logic [CHW-1:0] last;
  logic [CHW-1:0] fch;
  logic [CHW-1:0] cand;
  logic [CHW-1:0] sel;
  logic           sel_ok;
  logic           abort;
  fstate_t        fst;

  assign busy = play;

  // Round-robin pick: scanning from farthest to nearest leaves the nearest
  // eligible channel after the last served one as the winner.
  always_comb begin
    sel_ok = 1'b0;
    sel    = '0;
    cand   = '0;
    for (int k = CH; k >= 1; k--) begin
      cand = CHW'((int'(last) + k) % CH);
      if (play[cand] && !bvld[cand]) begin
        sel_ok = 1'b1;
        sel    = cand;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < CH; i++) begin
        start_r[i] <= '0;
        end_r[i]   <= '0;
        cur[i]     <= '0;
        bbyte[i]   <= '0;
      end
      loop_r    <= '0;
      hi        <= '0;
      bvld      <= '0;
      first_r   <= '0;
      play      <= '0;
      flags     <= '0;
      underrun  <= '0;
      sl        <= '0;
      last      <= CHW'(CH - 1);
      fch       <= '0;
      abort     <= 1'b0;
      fst       <= F_IDLE;
      rom_addr  <= '0;
      rom_cs    <= 1'b0;
      nib       <= '0;
      nib_ch    <= '0;
      nib_valid <= 1'b0;
      nib_clr   <= 1'b0;
    end else begin
      if (wr_start) start_r[wr_ch] <= wr_data;
      if (wr_end)   end_r[wr_ch]   <= wr_data;
      if (wr_loop)  loop_r[wr_ch]  <= loop_in;

      nib_valid <= 1'b0;

      case (fst)
        F_IDLE: begin
          if (sel_ok) begin
            fch      <= sel;
            last     <= sel;
            rom_addr <= cur[sel];
            rom_cs   <= 1'b1;
            abort    <= key_on[sel] | key_off[sel];
            fst      <= F_REQ;
          end
        end
        F_REQ: begin
          if (key_on[fch] || key_off[fch]) abort <= 1'b1;
          if (rom_ok) begin
            rom_cs <= 1'b0;
            fst    <= F_IDLE;
            // A key event during the request means the byte belongs to a stale address.
            if (!abort && !key_on[fch] && !key_off[fch]) begin
              bbyte[fch] <= rom_data;
              bvld[fch]  <= 1'b1;
            end
          end
        end
        default: fst <= F_IDLE;
      endcase

      if (cen) begin
        sl <= (sl == CHW'(CH - 1)) ? '0 : sl + 1'b1;
        if (play[sl]) begin
          if (bvld[sl]) begin
            nib_valid   <= 1'b1;
            nib         <= hi[sl] ? bbyte[sl][7:4] : bbyte[sl][3:0];
            nib_ch      <= sl;
            nib_clr     <= first_r[sl];
            first_r[sl] <= 1'b0;
            hi[sl]      <= !hi[sl];
            if (!hi[sl]) begin
              bvld[sl] <= 1'b0;
              if (cur[sl] == {end_r[sl], 8'hFF}) begin
                flags[sl] <= 1'b1;
                if (loop_r[sl]) cur[sl] <= {start_r[sl], 8'h00};
                else            play[sl] <= 1'b0;
              end else begin
                cur[sl] <= cur[sl] + 1'b1;
              end
            end
          end else begin
            underrun[sl] <= 1'b1;
          end
        end
      end

      // Key commands override the consume path; key_off overrides key_on.
      for (int i = 0; i < CH; i++) begin
        if (key_on[i]) begin
          cur[i]     <= {start_r[i], 8'h00};
          hi[i]      <= 1'b1;
          bvld[i]    <= 1'b0;
          first_r[i] <= 1'b1;
          play[i]    <= 1'b1;
        end
        if (key_off[i]) begin
          play[i] <= 1'b0;
          bvld[i] <= 1'b0;
        end
        if (clr_flags[i]) begin
          flags[i]    <= 1'b0;
          underrun[i] <= 1'b0;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: doc/jt10_adpcmx_seq.md
# jt10_adpcmx_seq

Parametrised ADPCM nibble sequencer for the JT10/JT12 sound-core family: holds per-channel start/end/current ROM addresses, fetches sample bytes through a ready/valid ROM port and emits one nibble per channel slot to a shared time-multiplexed ADPCM decoder. It generalises the fixed 6-channel ADPCM-A driver. The channel count and address width are parameters. ROM latency is variable, handled by a ready/valid handshake with per-channel byte buffers. It adds per-channel loop mode and underrun reporting.

## Interface
- CH, 6, number of channels (2..16); CHW = clog2(CH) localparam
- SW, 16, start/end register width; ROM byte address width AW = SW+8
- rst_n  in  1  asynchronous, active-low reset
- clk  in  1  clock
- cen  in  1  slot advance strobe (one channel slot per cen)
- wr_ch  in  CHW  channel targeted by register writes
- wr_start / wr_end  in  1  write wr_data into start / end register of wr_ch
- wr_loop  in  1  write loop_in into loop bit of wr_ch
- wr_data  in  SW  register data
- loop_in  in  1  loop enable value
- key_on / key_off  in  CH  single-clk command pulses, one bit per channel
- rom_addr  out  AW  byte address, stable while rom_cs high
- rom_cs  out  1  fetch request
- rom_data  in  8  ROM byte, valid with rom_ok
- rom_ok  in  1  fetch acknowledge
- nib  out  4  nibble to decoder
- nib_ch  out  CHW  channel owning nib
- nib_valid  out  1  one-clk strobe, nib/nib_ch/nib_clr valid
- nib_clr  out  1  decoder must reset this channel's state before decoding nib
- busy  out  CH  channel playing
- flags  out  CH  sticky end flag
- underrun  out  CH  sticky: slot arrived with empty buffer
- clr_flags  in  CH  clears flags and underrun bits (level, per bit)

## Operation
- Per channel: start[SW], end[SW], loop, cur[AW], hi (next nibble is high), buf[8], bvld, first, play.
- Slot pointer sl: 0..CH-1, advances on cen, wraps CH-1 -> 0.
- key_on[i]: cur <= {start,8'h00}, hi <= 1, bvld <= 0, first <= 1, play <= 1. key_off[i]: play <= 0, bvld <= 0. Both in same clk: key_off wins. Same channel key_on while playing: restart.
- Fetch engine (states IDLE, REQ): in IDLE it picks the lowest channel index >= last served + 1 (round-robin) with play & !bvld, latches it, drives rom_addr = cur, rom_cs = 1 -> REQ. On rom_ok: buf <= rom_data, bvld <= 1, unless the channel was keyed off/on during REQ, in which case data is discarded. Then IDLE, one idle clk before the next request.
- Slot consume on cen for channel sl:
  - play & bvld: emit nib = hi ? buf[7:4] : buf[3:0], nib_clr = first; first <= 0; hi toggles.
  - After a low nibble: bvld <= 0. If cur == {end,8'hFF}: flags <= 1. With loop, cur <= {start,8'h00} and first unchanged (decoder state kept); without loop, play <= 0. Otherwise cur <= cur+1, wrapping at 2^AW.
  - play & !bvld: no nib_valid; underrun <= 1; nibble position unchanged.
  - !play: nothing.
- Register writes take effect immediately. An end write on a playing channel applies to the next compare. A start write affects only later key_on or loop.
- clr_flags has priority over a same-clk flag set (flag stays clear).

## Timing
- Reset: sl = 0, all play/bvld/flags/underrun/busy = 0, start/end/loop = 0, rom_cs = 0, rom_addr = 0, nib = 0, nib_ch = 0, nib_valid = 0, nib_clr = 0, fetch state IDLE.
- nib/nib_ch/nib_valid/nib_clr registered: valid the clk after the consuming cen, held until the next cen, nib_valid high for exactly one clk.
- rom_cs rises the clk after selection; it falls the clk after rom_ok is sampled high. rom_ok with rom_cs low is ignored.
- A buffer filled in the same clk as its slot's cen is not consumed until the next visit.
- busy = play; it drops the clk after the final low nibble's cen, or after key_off.
- Fetch latency up to CH cen periods minus 2 clk never underruns with 2 nibbles per byte.

## Test plan
- CH=6, SW=16, start=end=0x0001, rom_ok 1 clk after rom_cs, key_on[2] -> fetches 0x000100..0x0001FF, 512 nibbles on nib_ch=2. First has nib_clr=1. flags[2] set on the last nibble, then busy[2]=0.
- Same with loop=1 -> after the nibble of 0x0001FF low, next fetch address 0x000100, nib_clr=0, flags[2]=1, busy stays 1.
- All 6 channels keyed on, rom_ok delayed 20 clk, cen every 8 clk -> underrun bits set, nibble order per channel unbroken, no address skipped.
- key_off[4] while its fetch is in REQ -> rom_data discarded, no nib for ch 4, next request goes to another channel.
- key_on and key_off on ch0 in the same clk -> busy[0]=0. clr_flags[2] in the same clk as the end event -> flags[2]=0.
- CH=3, SW=4 (AW=12), start=0xF, end=0x0 -> cur wraps 0xFFF -> 0x000, stops after 0x0FF.
